ram8_16: RTL

//   8-word x 16-bit register memory; the storage stage directly downstream of the
//   8-way 16-bit demultiplexer. The incoming word is steered to one of eight word

---
 rtl/ram8_16_pkg.sv | 41 ++++
 rtl/ram8_16_reg16.sv | 37 +++
 rtl/ram8_16.sv | 98 +++++++++
 3 files changed

// File: rtl/ram8_16_pkg.sv
// ============================================================================
// Package     : ram8_16_pkg
// Description : Shared constants, FSM state encoding and the 1-to-8 demux
//               tree used by the ram8_16 word-enable decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram8_16_pkg;

    localparam int WORD_W   = 16;  // data word width
    localparam int RAM8_AW  = 3;   // address width
    localparam int RAM8_DEP = 8;   // number of words

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // 1-to-8 demux built as a three-level binary tree (sel[2] first), the same
    // structure as the upstream data demux. Output bit sel_i carries bit_i.
    function automatic logic [7:0] demux8(input logic bit_i, input logic [2:0] sel_i);
        logic [1:0] l1;
        logic [3:0] l2;
        logic [7:0] l3;
        l1[0] = bit_i & ~sel_i[2];
        l1[1] = bit_i &  sel_i[2];
        for (int i = 0; i < 2; i++) begin
            l2[2*i]   = l1[i] & ~sel_i[1];
            l2[2*i+1] = l1[i] &  sel_i[1];
        end
        for (int j = 0; j < 4; j++) begin
            l3[2*j]   = l2[j] & ~sel_i[0];
            l3[2*j+1] = l2[j] &  sel_i[0];
        end
        return l3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram8_16_reg16.sv
// ============================================================================
// Module      : ram8_16_reg16
// Description : Word register with load enable and asynchronous clear.
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears q_o
//   load_i in   capture d_i on the next rising edge
//   d_i    in   data input
//   q_o    out  stored word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram8_16_reg16 #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/ram8_16.sv
// ============================================================================
// Module      : ram8_16
// Description : 8-word x 16-bit register memory with combinational read and
//               a one-word-per-cycle bulk-clear sequencer.
//   clock   in   single clock, all state changes on the rising edge
//   reset   in   asynchronous active-high reset, clears all words and the FSM
//   in      in   write data
//   load    in   write enable for word[address] (ignored while clearing)
//   address in   read/write word select
//   clear   in   request bulk clear (has priority over load)
//   out     out  word[address], combinational
//   busy    out  high while the clear sequence runs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram8_16
    import ram8_16_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in,
    input  logic               load,
    input  logic [RAM8_AW-1:0] address,
    input  logic               clear,
    output logic [WIDTH-1:0]   out,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [RAM8_AW-1:0] ptr_q, ptr_d;
    logic [RAM8_DEP-1:0] we;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   word_q [RAM8_DEP];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state plus write-enable source selection. In IDLE the demux tree
    // is driven by the user write (masked by clear so clear wins); in CLEAR it
    // is driven by a constant 1 steered by the sweep pointer with zero data.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = '0;
        wdata   = in;
        case (state_q)
            ST_IDLE: begin
                we = demux8(load & ~clear, address);
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                we    = demux8(1'b1, ptr_q);
                wdata = '0;
                if (ptr_q == RAM8_AW'(RAM8_DEP - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < RAM8_DEP; i++) begin : g_word
        ram8_16_reg16 #(
            .WIDTH (WIDTH)
        ) u_reg16 (
            .clock  (clock),
            .reset  (reset),
            .load_i (we[i]),
            .d_i    (wdata),
            .q_o    (word_q[i])
        );
    end

    assign out  = word_q[address];
    assign busy = (state_q == ST_CLEAR);

endmodule

`default_nettype wire
